// File: rtl/alu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_stage_pkg
// Brief   : Opcode, condition-code and flag-index constants for alu_stage.
// Revision: 1.0 - initial release
// ============================================================================
package alu_stage_pkg;

    localparam logic [3:0] c_OP_AND = 4'h0;
    localparam logic [3:0] c_OP_EOR = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_RSB = 4'h3;
    localparam logic [3:0] c_OP_ADD = 4'h4;
    localparam logic [3:0] c_OP_ADC = 4'h5;
    localparam logic [3:0] c_OP_SBC = 4'h6;
    localparam logic [3:0] c_OP_RSC = 4'h7;
    localparam logic [3:0] c_OP_TST = 4'h8;
    localparam logic [3:0] c_OP_TEQ = 4'h9;
    localparam logic [3:0] c_OP_CMP = 4'hA;
    localparam logic [3:0] c_OP_CMN = 4'hB;
    localparam logic [3:0] c_OP_ORR = 4'hC;
    localparam logic [3:0] c_OP_MOV = 4'hD;
    localparam logic [3:0] c_OP_BIC = 4'hE;
    localparam logic [3:0] c_OP_MVN = 4'hF;

    localparam logic [3:0] c_COND_EQ = 4'h0;
    localparam logic [3:0] c_COND_NE = 4'h1;
    localparam logic [3:0] c_COND_CS = 4'h2;
    localparam logic [3:0] c_COND_CC = 4'h3;
    localparam logic [3:0] c_COND_MI = 4'h4;
    localparam logic [3:0] c_COND_PL = 4'h5;
    localparam logic [3:0] c_COND_VS = 4'h6;
    localparam logic [3:0] c_COND_VC = 4'h7;
    localparam logic [3:0] c_COND_HI = 4'h8;
    localparam logic [3:0] c_COND_LS = 4'h9;
    localparam logic [3:0] c_COND_GE = 4'hA;
    localparam logic [3:0] c_COND_LT = 4'hB;
    localparam logic [3:0] c_COND_GT = 4'hC;
    localparam logic [3:0] c_COND_LE = 4'hD;
    localparam logic [3:0] c_COND_AL = 4'hE;
    localparam logic [3:0] c_COND_NV = 4'hF;

    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    // TST, TEQ, CMP and CMN occupy opcodes 8..B and never write a register.
    function automatic logic is_compare_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_stage_cond_check.sv
`default_nettype none
// ============================================================================
// Module  : cond_check
// Brief   : ARM condition-field evaluation against the current NZCV flags.
// Revision: 1.0 - initial release
// ============================================================================
module cond_check
    import alu_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[c_FLAG_N];
    assign w_z = flags[c_FLAG_Z];
    assign w_c = flags[c_FLAG_C];
    assign w_v = flags[c_FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            c_COND_EQ: pass = w_z;
            c_COND_NE: pass = !w_z;
            c_COND_CS: pass = w_c;
            c_COND_CC: pass = !w_c;
            c_COND_MI: pass = w_n;
            c_COND_PL: pass = !w_n;
            c_COND_VS: pass = w_v;
            c_COND_VC: pass = !w_v;
            c_COND_HI: pass = w_c && !w_z;
            c_COND_LS: pass = !w_c || w_z;
            c_COND_GE: pass = (w_n == w_v);
            c_COND_LT: pass = (w_n != w_v);
            c_COND_GT: pass = !w_z && (w_n == w_v);
            c_COND_LE: pass = w_z || (w_n != w_v);
            c_COND_AL: pass = 1'b1;
            default:   pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_stage
// Brief   : ARM-style execute stage: data-processing, branch, flags, squash.
// Revision: 1.0 - initial release
// ============================================================================
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s,
    input  logic        imm_en,
    input  logic [31:0] imm,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  rd,
    input  logic        isb,
    input  logic [23:0] boff,
    input  logic [31:0] pc,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    output logic        ib,
    output logic [31:0] bv,
    output logic [3:0]  flags
);

    localparam int              c_SQ_W    = $clog2(FLUSH_CYCLES + 2);
    localparam logic [c_SQ_W-1:0] c_SQ_LOAD = c_SQ_W'(FLUSH_CYCLES);
    localparam logic [c_SQ_W-1:0] c_SQ_ONE  = c_SQ_W'(1);

    logic [3:0]        r_flags;
    logic [c_SQ_W-1:0] r_squash;

    logic        w_pass;
    logic [31:0] w_op2;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_ci;
    logic        w_arith;
    logic [31:0] w_logic;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic [3:0]  w_flags_nxt;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_go;
    logic        w_br_take;
    logic        w_dp;
    logic        w_wr;
    logic        w_redirect;
    logic        w_flag_upd;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    assign w_op2 = imm_en ? imm : op_b;

    // Subtractions are folded into x + ~y + cin so bit 32 is directly NOT borrow.
    always_comb begin
        w_x     = op_a;
        w_y     = w_op2;
        w_ci    = 1'b0;
        w_arith = 1'b1;
        w_logic = 32'd0;
        case (opcode)
            c_OP_SUB, c_OP_CMP: begin w_y = ~w_op2; w_ci = 1'b1; end
            c_OP_RSB:           begin w_x = w_op2; w_y = ~op_a; w_ci = 1'b1; end
            c_OP_ADD, c_OP_CMN: begin w_ci = 1'b0; end
            c_OP_ADC:           begin w_ci = r_flags[c_FLAG_C]; end
            c_OP_SBC:           begin w_y = ~w_op2; w_ci = r_flags[c_FLAG_C]; end
            c_OP_RSC:           begin w_x = w_op2; w_y = ~op_a; w_ci = r_flags[c_FLAG_C]; end
            c_OP_AND, c_OP_TST: begin w_arith = 1'b0; w_logic = op_a & w_op2; end
            c_OP_EOR, c_OP_TEQ: begin w_arith = 1'b0; w_logic = op_a ^ w_op2; end
            c_OP_ORR:           begin w_arith = 1'b0; w_logic = op_a | w_op2; end
            c_OP_MOV:           begin w_arith = 1'b0; w_logic = w_op2; end
            c_OP_BIC:           begin w_arith = 1'b0; w_logic = op_a & ~w_op2; end
            default:            begin w_arith = 1'b0; w_logic = ~w_op2; end
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_ci};
    assign w_res = w_arith ? w_sum[31:0] : w_logic;

    always_comb begin
        w_flags_nxt           = r_flags;
        w_flags_nxt[c_FLAG_N] = w_res[31];
        w_flags_nxt[c_FLAG_Z] = (w_res == 32'd0);
        if (w_arith) begin
            w_flags_nxt[c_FLAG_C] = w_sum[32];
            w_flags_nxt[c_FLAG_V] = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
        end
    end

    assign w_target   = pc + 32'd8 + {{6{boff[23]}}, boff, 2'b00};

    assign w_accept   = in_valid && (r_squash == '0);
    assign w_go       = w_accept && w_pass;
    assign w_br_take  = w_go && isb;
    assign w_dp       = w_go && !isb;
    assign w_wr       = w_dp && !is_compare_op(opcode);
    assign w_redirect = w_br_take || (w_wr && (rd == 4'hF));
    assign w_flag_upd = w_dp && (is_compare_op(opcode) || s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we       <= 1'b0;
            wa       <= 4'd0;
            wd       <= 32'd0;
            ib       <= 1'b0;
            bv       <= 32'd0;
            r_flags  <= 4'b0000;
            r_squash <= '0;
        end else begin
            we <= w_wr;
            ib <= w_br_take;
            if (w_wr) begin
                wa <= rd;
                wd <= w_res;
            end
            if (w_br_take) begin
                bv <= w_target;
            end
            if (w_flag_upd) begin
                r_flags <= w_flags_nxt;
            end
            if (w_redirect) begin
                r_squash <= c_SQ_LOAD;
            end else if (r_squash != '0) begin
                r_squash <= r_squash - c_SQ_ONE;
            end
        end
    end

    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_stage
// Brief   : Directed self-checking bench for alu_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  cond = 4'hE;
    logic [3:0]  opcode = 4'h0;
    logic        s = 1'b0;
    logic        imm_en = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [3:0]  rd = 4'd0;
    logic        isb = 1'b0;
    logic [23:0] boff = 24'd0;
    logic [31:0] pc = 32'd0;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        ib;
    logic [31:0] bv;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    alu_stage #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cond(cond),
        .opcode(opcode), .s(s), .imm_en(imm_en), .imm(imm), .op_a(op_a),
        .op_b(op_b), .rd(rd), .isb(isb), .boff(boff), .pc(pc),
        .we(we), .wa(wa), .wd(wd), .ib(ib), .bv(bv), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dp(input logic [3:0] c, input logic [3:0] op, input logic sf,
                      input logic ie, input logic [31:0] iv, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] r);
        in_valid = 1'b1; isb = 1'b0; cond = c; opcode = op; s = sf;
        imm_en = ie; imm = iv; op_a = a; op_b = b; rd = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic br(input logic [3:0] c, input logic [31:0] p, input logic [23:0] o);
        in_valid = 1'b1; isb = 1'b1; cond = c; pc = p; boff = o;
        tick();
        in_valid = 1'b0; isb = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({we, wa, wd, ib, bv, flags} !== 74'd0) begin
            errors++;
            $display("FAIL reset: got %h exp 0", {we, wa, wd, ib, bv, flags});
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mov_adds();
        dp(4'hE, 4'hD, 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 4'd1);
        checks++;
        if ({we, wa, wd, flags} !== {1'b1, 4'd1, 32'd5, 4'b0000}) begin
            errors++;
            $display("FAIL mov: got %h exp %h", {we, wa, wd, flags}, {1'b1, 4'd1, 32'd5, 4'b0000});
        end
        dp(4'hE, 4'h4, 1'b1, 1'b1, 32'hFFFFFFFB, 32'd5, 32'd0, 4'd2);
        checks++;
        if ({we, wa, wd, flags} !== {1'b1, 4'd2, 32'd0, 4'b0110}) begin
            errors++;
            $display("FAIL adds: got %h exp %h", {we, wa, wd, flags}, {1'b1, 4'd2, 32'd0, 4'b0110});
        end
    endtask

    task automatic test_cmp();
        dp(4'hE, 4'hA, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0, 4'd3);
        checks++;
        if ({we, ib, flags} !== {1'b0, 1'b0, 4'b1001}) begin
            errors++;
            $display("FAIL cmp: got %b exp %b", {we, ib, flags}, {1'b0, 1'b0, 4'b1001});
        end
    endtask

    task automatic test_branch_cond();
        // MOVS r3,#0: Z=1, N=0, C/V held from CMP (0,1)
        dp(4'hE, 4'hD, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 4'd3);
        checks++;
        if (flags !== 4'b0101) begin
            errors++;
            $display("FAIL movs_flags: got %b exp 0101", flags);
        end
        br(4'h1, 32'h100, 24'h000004);
        checks++;
        if ({ib, we} !== 2'b00) begin
            errors++;
            $display("FAIL bne: got %b exp 00", {ib, we});
        end
        br(4'h0, 32'h100, 24'h000004);
        checks++;
        if ({ib, we, bv} !== {1'b1, 1'b0, 32'h118}) begin
            errors++;
            $display("FAIL beq: got %h exp %h", {ib, we, bv}, {1'b1, 1'b0, 32'h118});
        end
        idle();
        checks++;
        if ({ib, bv} !== {1'b0, 32'h118}) begin
            errors++;
            $display("FAIL beq_pulse: got %h exp %h", {ib, bv}, {1'b0, 32'h118});
        end
        idle();
    endtask

    task automatic test_arith();
        // flags enter as 0101
        dp(4'hE, 4'h4, 1'b1, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd5);
        checks++;
        if ({wd, flags} !== {32'd0, 4'b0110}) begin
            errors++;
            $display("FAIL adds_carry: got %h exp %h", {wd, flags}, {32'd0, 4'b0110});
        end
        dp(4'hE, 4'h5, 1'b0, 1'b0, 32'd0, 32'd1, 32'd2, 4'd6);
        checks++;
        if ({we, wa, wd, flags} !== {1'b1, 4'd6, 32'd4, 4'b0110}) begin
            errors++;
            $display("FAIL adc: got %h exp %h", {we, wa, wd, flags}, {1'b1, 4'd6, 32'd4, 4'b0110});
        end
        dp(4'hE, 4'h6, 1'b1, 1'b0, 32'd0, 32'd5, 32'd3, 4'd7);
        checks++;
        if ({wd, flags} !== {32'd2, 4'b0010}) begin
            errors++;
            $display("FAIL sbcs: got %h exp %h", {wd, flags}, {32'd2, 4'b0010});
        end
        dp(4'hE, 4'h3, 1'b1, 1'b1, 32'd1, 32'd3, 32'd0, 4'd8);
        checks++;
        if ({wd, flags} !== {32'hFFFFFFFE, 4'b1000}) begin
            errors++;
            $display("FAIL rsbs: got %h exp %h", {wd, flags}, {32'hFFFFFFFE, 4'b1000});
        end
        dp(4'hE, 4'h7, 1'b0, 1'b1, 32'd5, 32'd1, 32'd0, 4'd9);
        checks++;
        if ({wd, flags} !== {32'd3, 4'b1000}) begin
            errors++;
            $display("FAIL rsc: got %h exp %h", {wd, flags}, {32'd3, 4'b1000});
        end
        dp(4'hE, 4'h8, 1'b0, 1'b0, 32'd0, 32'h0F, 32'hF0, 4'd10);
        checks++;
        if ({we, flags} !== {1'b0, 4'b0100}) begin
            errors++;
            $display("FAIL tst: got %b exp %b", {we, flags}, {1'b0, 4'b0100});
        end
        dp(4'hE, 4'hB, 1'b0, 1'b1, 32'd1, 32'h7FFFFFFF, 32'd0, 4'd10);
        checks++;
        if ({we, flags} !== {1'b0, 4'b1001}) begin
            errors++;
            $display("FAIL cmn: got %b exp %b", {we, flags}, {1'b0, 4'b1001});
        end
    endtask

    task automatic test_logic_and_nop();
        // ANDS keeps C/V (0,1): result 0x80000000 -> NZCV 1001
        dp(4'hE, 4'h0, 1'b1, 1'b0, 32'd0, 32'h80000000, 32'hF0000000, 4'd4);
        checks++;
        if ({wa, wd, flags} !== {4'd4, 32'h80000000, 4'b1001}) begin
            errors++;
            $display("FAIL ands: got %h exp %h", {wa, wd, flags}, {4'd4, 32'h80000000, 4'b1001});
        end
        dp(4'h0, 4'h4, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 4'd10);
        checks++;
        if ({we, ib, wa, wd, flags} !== {1'b0, 1'b0, 4'd4, 32'h80000000, 4'b1001}) begin
            errors++;
            $display("FAIL cond_fail: got %h exp %h", {we, ib, wa, wd, flags},
                     {1'b0, 1'b0, 4'd4, 32'h80000000, 4'b1001});
        end
        dp(4'hF, 4'hD, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 4'd11);
        checks++;
        if ({we, flags} !== {1'b0, 4'b1001}) begin
            errors++;
            $display("FAIL nv: got %b exp %b", {we, flags}, {1'b0, 4'b1001});
        end
    endtask

    task automatic test_back_to_back();
        br(4'hE, 32'h20, 24'hFFFFFE);
        checks++;
        if ({ib, we, bv} !== {1'b1, 1'b0, 32'h20}) begin
            errors++;
            $display("FAIL b_back: got %h exp %h", {ib, we, bv}, {1'b1, 1'b0, 32'h20});
        end
        for (int i = 0; i < 2; i++) begin
            dp(4'hE, 4'h4, 1'b1, 1'b0, 32'd0, 32'd1, 32'd1, 4'd1);
            checks++;
            if ({we, ib, flags, bv} !== {1'b0, 1'b0, 4'b1001, 32'h20}) begin
                errors++;
                $display("FAIL squash_%0d: got %h exp %h", i, {we, ib, flags, bv},
                         {1'b0, 1'b0, 4'b1001, 32'h20});
            end
        end
        dp(4'hE, 4'h4, 1'b0, 1'b1, 32'd3, 32'd2, 32'd0, 4'd3);
        checks++;
        if ({we, wa, wd} !== {1'b1, 4'd3, 32'd5}) begin
            errors++;
            $display("FAIL post_squash: got %h exp %h", {we, wa, wd}, {1'b1, 4'd3, 32'd5});
        end
    endtask

    task automatic test_pc_write();
        dp(4'hE, 4'h2, 1'b1, 1'b1, 32'd4, 32'h200, 32'd0, 4'd15);
        checks++;
        if ({we, wa, wd, ib, flags} !== {1'b1, 4'd15, 32'h1FC, 1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL subs_pc: got %h exp %h", {we, wa, wd, ib, flags},
                     {1'b1, 4'd15, 32'h1FC, 1'b0, 4'b0010});
        end
        for (int i = 0; i < 2; i++) begin
            dp(4'hE, 4'hD, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 4'd1);
            checks++;
            if ({we, flags} !== {1'b0, 4'b0010}) begin
                errors++;
                $display("FAIL pc_squash_%0d: got %b exp %b", i, {we, flags}, {1'b0, 4'b0010});
            end
        end
        dp(4'hE, 4'hD, 1'b0, 1'b1, 32'd7, 32'd0, 32'd0, 4'd1);
        checks++;
        if ({we, wa, wd} !== {1'b1, 4'd1, 32'd7}) begin
            errors++;
            $display("FAIL pc_post: got %h exp %h", {we, wa, wd}, {1'b1, 4'd1, 32'd7});
        end
    endtask

    task automatic test_reset_mid();
        br(4'hE, 32'h40, 24'h000000);
        checks++;
        if ({ib, bv} !== {1'b1, 32'h48}) begin
            errors++;
            $display("FAIL b_pre_rst: got %h exp %h", {ib, bv}, {1'b1, 32'h48});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({we, ib, bv, flags} !== 38'd0) begin
            errors++;
            $display("FAIL async_rst: got %h exp 0", {we, ib, bv, flags});
        end
        #1 rst_n = 1'b1;
        dp(4'hE, 4'h4, 1'b0, 1'b0, 32'd0, 32'd10, 32'd20, 4'd4);
        checks++;
        if ({we, wa, wd, ib} !== {1'b1, 4'd4, 32'd30, 1'b0}) begin
            errors++;
            $display("FAIL post_rst_add: got %h exp %h", {we, wa, wd, ib}, {1'b1, 4'd4, 32'd30, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_mov_adds();
        test_cmp();
        test_branch_cond();
        test_arith();
        test_logic_and_nop();
        test_back_to_back();
        test_pc_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
